wave_control: RTL and testbench
===============================

# wave_control

Enemy-wave sequencer: owns the enemy `plane_amount`, consumes the per-slot visibility mask decoded from it, and tracks which planes are still alive as hits arrive. When every plane in a wave is destroyed, it waits a respawn delay, grows the wave by one plane (saturating at 10), and reloads. It sits between the collision logic (hit pulses) and the enemy drawing/movement logic (alive mask).

## Interface
Parameters:
- `RESPAWN_DELAY`, default 50_000_000: cycles spent in the clear-wait state. Must be ≥ 1.
- `START_AMOUNT`, default 1: `plane_amount` after reset. Range 1–10.
- `MAX_AMOUNT`, default 10: saturation limit for `plane_amount`. Range 1–10.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle game-start pulse. Honoured only in IDLE.
- `vis` in 10: thermometer mask decoded from `plane_amount` (bit i set = slot i used). Arrives combinationally from the amount decoder.
- `hit` in 10: per-slot hit pulses from collision logic.
- `plane_amount` out 4: current wave size, registered.
- `alive` out 10: registered per-slot alive mask.
- `alive_count` out 4: popcount of `alive`. Combinational from the `alive` register.
- `load_wave` out 1: one-cycle pulse while in LOAD.
- `wave_done` out 1: one-cycle pulse on the PLAY→CLEAR_WAIT transition.

## Operation
FSM states are IDLE, LOAD, PLAY and CLEAR_WAIT.
- **IDLE**
  - `alive` is held at 0.
  - `start` = 1 → LOAD.
- **LOAD** (exactly 1 cycle)
  - `alive <= vis`; `load_wave` = 1.
  - `hit` is ignored.
  - Next state: PLAY.
- **PLAY**
  - `alive <= alive & ~hit`.
  - Hits on slots already dead or unused have no effect.
  - When registered `alive` == 0: assert `wave_done` for that cycle, clear the delay counter, go to CLEAR_WAIT.
  - The kill cycle (alive 1→0) is followed by one PLAY cycle with `alive` == 0, in which `wave_done` fires.
- **CLEAR_WAIT**
  - The delay counter increments each cycle.
  - `hit` is ignored and `alive` stays 0.
  - When the counter == `RESPAWN_DELAY`−1: `plane_amount <= min(plane_amount+1, MAX_AMOUNT)`, go to LOAD.
  - Because `vis` follows `plane_amount` combinationally, LOAD samples the enlarged mask.
- `start` outside IDLE is ignored.
- Arithmetic: the increment is done in 5 bits before comparing, so there is no 4-bit wrap.
- The delay counter is `$clog2(RESPAWN_DELAY+1)` bits wide and never wraps.

## Timing
- Reset values: state IDLE, `plane_amount` = `START_AMOUNT`, `alive` = 0, `alive_count` = 0, `load_wave` = 0, `wave_done` = 0, delay counter = 0, `kills` = 0.
- Reset asserted mid-wave returns to IDLE on the next edge, with all outputs at reset values.
- `start` at edge N → LOAD during cycle N+1, `load_wave` high → `alive` = `vis` from edge N+2 onward.
- `hit` at edge N → `alive` bit clears at edge N (visible in cycle N+1); `alive_count` tracks in the same cycle.
- Last kill at edge K → `wave_done` high in cycle K+1 → CLEAR_WAIT lasts `RESPAWN_DELAY` cycles → LOAD → `alive` reloaded `RESPAWN_DELAY`+2 cycles after `wave_done`.
- When a wave is already at `MAX_AMOUNT`, `plane_amount` holds its value and waves repeat at full size.

## Configuration
- `WAVE_CONTROL_KILLS_EN` defined:
  - Adds output `kills` (16 bits).
  - In PLAY only, `kills` increments each cycle by popcount(`alive & hit`), saturating at 16'hFFFF.
  - `kills` is cleared by reset only.
- Undefined: no `kills` port and no counter logic.

## Structure
- Package `wave_pkg` holds:
  - the state enum (IDLE, LOAD, PLAY, CLEAR_WAIT);
  - `MAX_PLANES` = 10;
  - `AMOUNT_W` = 4.
- Sub-module `plane_counter`: a 10-bit → 4-bit combinational popcount. It is used for `alive_count` and, when enabled, for the kill increment.

## Test plan
- **Reset, then start:** reset, then pulse `start` with `START_AMOUNT`=1 and `vis` = 10'b1 → `load_wave` high one cycle, then `alive` = 10'b1 and `alive_count` = 1.
- **Hits on dead/unused slots:** in PLAY with `alive` = 10'b111, pulse `hit` = 10'b1010 → `alive` = 10'b101, `alive_count` = 2. A repeated `hit` on bit 1 changes nothing.
- **Wave clear and regrow:** `RESPAWN_DELAY` = 4, kill the last plane → one `wave_done` pulse, then exactly 4 CLEAR_WAIT cycles, `plane_amount` 1→2, and LOAD samples `vis` = 10'b11.
- **Saturation:** `plane_amount` = 10, clear the wave → `plane_amount` stays 10 and `alive` reloads to 10'h3FF.
- **Reset mid-wave:** assert `reset` in CLEAR_WAIT at counter = 2 → state IDLE, `plane_amount` = `START_AMOUNT`, and no `load_wave` until the next `start`.
- **Kills counter (`WAVE_CONTROL_KILLS_EN`):** simultaneous `hit` = 10'h3FF with `alive` = 10'h00F → `kills` += 4. Hits during LOAD or CLEAR_WAIT do not count.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and sizes for the enemy-wave sequencer.
package wave_pkg;

    localparam int MAX_PLANES = 10;
    localparam int AMOUNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        CLEAR_WAIT
    } wave_state_e;

endpackage

// File: rtl/plane_counter.sv
// Combinational popcount of a per-slot plane mask.
module plane_counter
    import wave_pkg::*;
(
    input  logic [MAX_PLANES-1:0] bits,
    output logic [AMOUNT_W-1:0]   count
);

    // Sum the set bits; ten slots always fit in four bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < MAX_PLANES; i++) begin
            count = count + AMOUNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/wave_control.sv
// Enemy-wave sequencer: loads the alive mask from the visibility mask, clears
// slots on hits, and after a cleared wave waits a respawn delay before loading
// a wave one plane larger (saturating at MAX_AMOUNT).
// Optional build macro WAVE_CONTROL_KILLS_EN adds a saturating 16-bit kill
// counter output.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start, alive held at 0
// LOAD       | one cycle: alive <= vis, load_wave high
// PLAY       | hits clear alive bits; empty alive ends the wave
// CLEAR_WAIT | respawn delay, then grow plane_amount and reload
module wave_control
    import wave_pkg::*;
#(
    parameter int RESPAWN_DELAY = 50_000_000,
    parameter int START_AMOUNT  = 1,
    parameter int MAX_AMOUNT    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MAX_PLANES-1:0] vis,
    input  logic [MAX_PLANES-1:0] hit,
    output logic [AMOUNT_W-1:0]   plane_amount,
    output logic [MAX_PLANES-1:0] alive,
    output logic [AMOUNT_W-1:0]   alive_count,
    output logic                  load_wave,
    output logic                  wave_done
`ifdef WAVE_CONTROL_KILLS_EN
    ,
    output logic [15:0]           kills
`endif
);

    localparam int CNT_W = $clog2(RESPAWN_DELAY + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RESPAWN_DELAY - 1);
    localparam logic [AMOUNT_W:0]   MAX_EXT   = (AMOUNT_W + 1)'(MAX_AMOUNT);
    localparam logic [AMOUNT_W-1:0] START_VAL = AMOUNT_W'(START_AMOUNT);

    wave_state_e           state;
    logic [CNT_W-1:0]      delay_cnt;
    logic [MAX_PLANES-1:0] alive_next;
    logic [AMOUNT_W:0]     amount_inc;
    logic [AMOUNT_W-1:0]   amount_grown;

    // Next alive mask under hits, and the next wave size computed one bit
    // wider so the increment cannot wrap before the saturation compare.
    always_comb begin
        alive_next   = alive & ~hit;
        amount_inc   = {1'b0, plane_amount} + (AMOUNT_W + 1)'(1);
        amount_grown = (amount_inc > MAX_EXT) ? MAX_EXT[AMOUNT_W-1:0]
                                              : amount_inc[AMOUNT_W-1:0];
    end

    plane_counter u_alive_count (
        .bits  (alive),
        .count (alive_count)
    );

    // Wave FSM; wave_done is raised on the edge that makes alive empty so it
    // is high exactly in the PLAY cycle that observes alive == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            plane_amount <= START_VAL;
            alive        <= '0;
            load_wave    <= 1'b0;
            wave_done    <= 1'b0;
            delay_cnt    <= '0;
        end else begin
            load_wave <= 1'b0;
            wave_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    alive <= '0;
                    if (start) begin
                        state     <= LOAD;
                        load_wave <= 1'b1;
                    end
                end
                LOAD: begin
                    alive     <= vis;
                    state     <= PLAY;
                    wave_done <= (vis == '0);
                end
                PLAY: begin
                    if (alive == '0) begin
                        state     <= CLEAR_WAIT;
                        delay_cnt <= '0;
                    end else begin
                        alive     <= alive_next;
                        wave_done <= (alive_next == '0);
                    end
                end
                CLEAR_WAIT: begin
                    alive     <= '0;
                    delay_cnt <= delay_cnt + CNT_W'(1);
                    if (delay_cnt == CNT_LAST) begin
                        plane_amount <= amount_grown;
                        state        <= LOAD;
                        load_wave    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WAVE_CONTROL_KILLS_EN
    logic [MAX_PLANES-1:0] hit_live;
    logic [AMOUNT_W-1:0]   kill_inc;
    logic [16:0]           kills_sum;

    // Only hits on live planes score a kill.
    always_comb begin
        hit_live  = alive & hit;
        kills_sum = {1'b0, kills} + 17'(kill_inc);
    end

    plane_counter u_kill_count (
        .bits  (hit_live),
        .count (kill_inc)
    );

    // Saturating kill tally, advanced only while a wave is in play.
    always_ff @(posedge clk) begin
        if (reset) begin
            kills <= '0;
        end else if (state == PLAY) begin
            kills <= kills_sum[16] ? 16'hFFFF : kills_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_wave_control.sv
// Self-checking bench for wave_control: a directed vector table, a few
// hand-written multi-cycle sequences, and a random run against a behavioural
// model of the wave rules.
module tb_wave_control;

    localparam int D    = 4;
    localparam int STA  = 1;
    localparam int MAXA = 10;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_PLAY = 2;
    localparam int PH_WAIT = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] vis;
    logic [9:0] hit;
    logic [3:0] plane_amount;
    logic [9:0] alive;
    logic [3:0] alive_count;
    logic       load_wave;
    logic       wave_done;
`ifdef WAVE_CONTROL_KILLS_EN
    logic [15:0] kills;
`endif

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // behavioural model
    int         m_phase;
    int         m_wait;
    int         m_amount;
    logic [9:0] m_alive;
    int         m_kills;

    function automatic logic [9:0] thermo(input int n);
        int v;
        v = (1 << n) - 1;
        return v[9:0];
    endfunction

    // amount decoder feeding vis
    assign vis = thermo(int'(plane_amount));

    wave_control #(
        .RESPAWN_DELAY (D),
        .START_AMOUNT  (STA),
        .MAX_AMOUNT    (MAXA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .vis          (vis),
        .hit          (hit),
        .plane_amount (plane_amount),
        .alive        (alive),
        .alive_count  (alive_count),
        .load_wave    (load_wave),
        .wave_done    (wave_done)
`ifdef WAVE_CONTROL_KILLS_EN
        ,
        .kills        (kills)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [9:0] h);
        if (r) begin
            m_phase  = PH_IDLE;
            m_wait   = 0;
            m_amount = STA;
            m_alive  = '0;
            m_kills  = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (s) m_phase = PH_LOAD;
                PH_LOAD: begin
                    m_alive = thermo(m_amount);
                    m_phase = PH_PLAY;
                end
                PH_PLAY: begin
                    if (m_alive == '0) begin
                        m_phase = PH_WAIT;
                        m_wait  = D;
                    end else begin
                        m_kills = m_kills + $countones(m_alive & h);
                        if (m_kills > 65535) m_kills = 65535;
                        m_alive = m_alive & ~h;
                    end
                end
                default: begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) begin
                        m_amount = (m_amount + 1 > MAXA) ? MAXA : m_amount + 1;
                        m_phase  = PH_LOAD;
                    end
                end
            endcase
        end
    endtask

    task automatic check_model();
        chk("plane_amount", 32'(plane_amount), 32'(m_amount));
        chk("alive", 32'(alive), 32'(m_alive));
        chk("alive_count", 32'(alive_count), 32'($countones(m_alive)));
        chk("load_wave", 32'(load_wave), 32'(m_phase == PH_LOAD));
        chk("wave_done", 32'(wave_done), 32'(m_phase == PH_PLAY && m_alive == '0));
`ifdef WAVE_CONTROL_KILLS_EN
        chk("kills", 32'(kills), 32'(m_kills));
`endif
    endtask

    // one clock: drive inputs, advance model on the edge, compare 1 ns later
    task automatic step(input logic r, input logic s, input logic [9:0] h);
        reset = r;
        start = s;
        hit   = h;
        @(posedge clk);
        model_edge(r, s, h);
        #1;
        cycle++;
        check_model();
    endtask

    typedef struct {
        logic       r;
        logic       s;
        logic [9:0] h;
        logic [9:0] exp_alive;
        int         exp_cnt;
        logic       exp_ld;
        logic       exp_dn;
        int         exp_amt;
    } vec_t;

    vec_t tbl[22];
    int   sat_seen;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hit   = '0;
        m_phase = PH_IDLE; m_wait = 0; m_amount = STA; m_alive = '0; m_kills = 0;

        // reset, start, first wave, clear, regrow to 2 and 3, dead-slot hits
        tbl[0]  = '{1'b1, 1'b0, 10'h000, 10'h000, 0, 1'b0, 1'b0, 1};
        tbl[1]  = '{1'b0, 1'b1, 10'h000, 10'h000, 0, 1'b1, 1'b0, 1};
        tbl[2]  = '{1'b0, 1'b0, 10'h000, 10'h001, 1, 1'b0, 1'b0, 1};
        tbl[3]  = '{1'b0, 1'b0, 10'h002, 10'h001, 1, 1'b0, 1'b0, 1};
        tbl[4]  = '{1'b0, 1'b0, 10'h001, 10'h000, 0, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b0, 1'b0, 10'h001, 10'h000, 0, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b1, 10'h3FF, 10'h000, 0, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b1, 1'b0, 2};
        tbl[10] = '{1'b0, 1'b0, 10'h3FF, 10'h003, 2, 1'b0, 1'b0, 2};
        tbl[11] = '{1'b0, 1'b0, 10'h002, 10'h001, 1, 1'b0, 1'b0, 2};
        tbl[12] = '{1'b0, 1'b0, 10'h002, 10'h001, 1, 1'b0, 1'b0, 2};
        tbl[13] = '{1'b0, 1'b0, 10'h001, 10'h000, 0, 1'b0, 1'b1, 2};
        tbl[14] = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b0, 1'b0, 2};
        tbl[15] = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b0, 1'b0, 2};
        tbl[16] = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b0, 1'b0, 2};
        tbl[17] = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b0, 1'b0, 2};
        tbl[18] = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b1, 1'b0, 3};
        tbl[19] = '{1'b0, 1'b0, 10'h000, 10'h007, 3, 1'b0, 1'b0, 3};
        tbl[20] = '{1'b0, 1'b0, 10'h00A, 10'h005, 2, 1'b0, 1'b0, 3};
        tbl[21] = '{1'b0, 1'b0, 10'h002, 10'h005, 2, 1'b0, 1'b0, 3};

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].h);
            chk($sformatf("tbl%0d_alive", i), 32'(alive), 32'(tbl[i].exp_alive));
            chk($sformatf("tbl%0d_count", i), 32'(alive_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_load", i), 32'(load_wave), 32'(tbl[i].exp_ld));
            chk($sformatf("tbl%0d_done", i), 32'(wave_done), 32'(tbl[i].exp_dn));
            chk($sformatf("tbl%0d_amount", i), 32'(plane_amount), 32'(tbl[i].exp_amt));
        end

        // reset in CLEAR_WAIT with the delay counter at 2
        step(1'b0, 1'b0, 10'h005);
        chk("last_kill_done", 32'(wave_done), 32'd1);
        step(1'b0, 1'b0, 10'h000);
        step(1'b0, 1'b0, 10'h000);
        step(1'b0, 1'b0, 10'h000);
        step(1'b1, 1'b0, 10'h000);
        chk("reset_mid_amount", 32'(plane_amount), 32'(STA));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 10'h3FF);
            chk("no_load_after_reset", 32'(load_wave), 32'd0);
            chk("idle_alive_zero", 32'(alive), 32'd0);
        end

        // start, then hits during LOAD are ignored
        step(1'b0, 1'b1, 10'h000);
        step(1'b0, 1'b1, 10'h3FF);
        chk("load_ignores_hit", 32'(alive), 32'h001);

        // random run against the model
        sat_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       s;
            logic [9:0] h;
            r = (i > 1500) && ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) h = 10'h3FF;
            else h = 10'($urandom & $urandom);
            step(r, s, h);
            if (plane_amount == 4'd10 && alive == 10'h3FF) sat_seen++;
        end
        chk("saturated_reload_seen", 32'(sat_seen != 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
